// File: rtl/fib_tx_arb2_if.sv
// Signal bundle between the two-channel fibre tx arbiter, its per-channel
// data / byte-count FIFOs and the FMAC tx and IPCS FIFOs.
interface fib_tx_arb2_if #(
  parameter int DATA_WIDTH = 64,
  parameter int BCNT_WIDTH = 32
);
  logic                  rdempty_wf0;
  logic                  rdempty_wcf0;
  logic [DATA_WIDTH-1:0] dataout_wf0;
  logic [BCNT_WIDTH-1:0] dataout_wcf0;
  logic                  rden_wf0;
  logic                  rden_wcf0;

  logic                  rdempty_wf1;
  logic                  rdempty_wcf1;
  logic [DATA_WIDTH-1:0] dataout_wf1;
  logic [BCNT_WIDTH-1:0] dataout_wcf1;
  logic                  rden_wf1;
  logic                  rden_wcf1;

  logic [12:0]           fib_mac_usedw;
  logic [DATA_WIDTH-1:0] fib_mac_data;
  logic                  fib_mac_wr;
  logic [DATA_WIDTH-1:0] fib_mac_ipcs_data;
  logic                  fib_mac_ipcs_wr;

  logic [1:0]            grant;
  logic                  pkt_done;
  logic                  err_zero;

  modport master (
    input  rdempty_wf0, rdempty_wcf0, dataout_wf0, dataout_wcf0,
           rdempty_wf1, rdempty_wcf1, dataout_wf1, dataout_wcf1,
           fib_mac_usedw,
    output rden_wf0, rden_wcf0, rden_wf1, rden_wcf1,
           fib_mac_data, fib_mac_wr, fib_mac_ipcs_data, fib_mac_ipcs_wr,
           grant, pkt_done, err_zero
  );

  modport slave (
    output rdempty_wf0, rdempty_wcf0, dataout_wf0, dataout_wcf0,
           rdempty_wf1, rdempty_wcf1, dataout_wf1, dataout_wcf1,
           fib_mac_usedw,
    input  rden_wf0, rden_wcf0, rden_wf1, rden_wcf1,
           fib_mac_data, fib_mac_wr, fib_mac_ipcs_data, fib_mac_ipcs_wr,
           grant, pkt_done, err_zero
  );
endinterface

// File: rtl/fib_tx_arb2.sv
// Two-channel round-robin packet arbiter: reads a byte count, waits for FMAC
// space, writes the count word then forwards ceil(bcnt/8) qwords.
module fib_tx_arb2 #(
  parameter int DATA_WIDTH = 64,
  parameter int BCNT_WIDTH = 32
) (
  input  logic          clk_fib,
  input  logic          reset_,
  fib_tx_arb2_if.master bus
);

  typedef enum logic [5:0] {
    IDLE       = 6'b000001,
    CNT_RD     = 6'b000010,
    CNT_LAT    = 6'b000100,
    WAIT_SPACE = 6'b001000,
    DATA       = 6'b010000,
    DONE       = 6'b100000
  } state_t;

  state_t                state_r;
  logic                  ch_r;
  logic                  last_grant_r;
  logic                  zero_drop_r;
  logic                  rd_vld_r;
  logic [1:0]            grant_r;
  logic [1:0]            rden_wf_r;
  logic [1:0]            rden_wcf_r;
  logic [BCNT_WIDTH-1:0] cnt_word_r;
  logic [13:0]           qw_r;
  logic [13:0]           remaining_r;
  logic [DATA_WIDTH-1:0] mac_data_r;
  logic [DATA_WIDTH-1:0] ipcs_data_r;
  logic                  mac_wr_r;
  logic                  ipcs_wr_r;
  logic                  pkt_done_r;
  logic                  err_zero_r;

  logic                  req0_s;
  logic                  req1_s;
  logic                  empty_sel_s;
  logic                  pop_s;
  logic [DATA_WIDTH-1:0] data_sel_s;
  logic [BCNT_WIDTH-1:0] bcnt_sel_s;
  logic [16:0]           qw_sum_s;
  logic [13:0]           free_s;
  logic [13:0]           rem_next_s;

  // Channel muxing, qword count, FMAC free space and effective FIFO pops.
  always_comb begin
    req0_s = ~bus.rdempty_wf0 & ~bus.rdempty_wcf0;
    req1_s = ~bus.rdempty_wf1 & ~bus.rdempty_wcf1;
    if (ch_r) begin
      empty_sel_s = bus.rdempty_wf1;
      data_sel_s  = bus.dataout_wf1;
      bcnt_sel_s  = bus.dataout_wcf1;
    end else begin
      empty_sel_s = bus.rdempty_wf0;
      data_sel_s  = bus.dataout_wf0;
      bcnt_sel_s  = bus.dataout_wcf0;
    end
    // 17-bit sum so that bcnt=16'hFFFF rounds up to 8192 without wrapping
    qw_sum_s = {1'b0, bcnt_sel_s[15:0]} + 17'd7;
    free_s   = {1'b0, 13'h1FFF} - {1'b0, bus.fib_mac_usedw};
    // A read strobe issued into an empty FIFO is not a pop
    pop_s    = rden_wf_r[ch_r] & ~empty_sel_s;
    if (pop_s) begin
      rem_next_s = remaining_r - 14'd1;
    end else begin
      rem_next_s = remaining_r;
    end
  end

  // Packet FSM with all outputs registered.
  always_ff @(posedge clk_fib) begin
    if (!reset_) begin
      state_r      <= IDLE;
      ch_r         <= 1'b0;
      last_grant_r <= 1'b1;
      zero_drop_r  <= 1'b0;
      rd_vld_r     <= 1'b0;
      grant_r      <= 2'b00;
      rden_wf_r    <= 2'b00;
      rden_wcf_r   <= 2'b00;
      cnt_word_r   <= {BCNT_WIDTH{1'b0}};
      qw_r         <= 14'd0;
      remaining_r  <= 14'd0;
      mac_data_r   <= {DATA_WIDTH{1'b0}};
      ipcs_data_r  <= {DATA_WIDTH{1'b0}};
      mac_wr_r     <= 1'b0;
      ipcs_wr_r    <= 1'b0;
      pkt_done_r   <= 1'b0;
      err_zero_r   <= 1'b0;
    end else begin
      rden_wcf_r <= 2'b00;
      mac_wr_r   <= 1'b0;
      ipcs_wr_r  <= 1'b0;
      pkt_done_r <= 1'b0;
      err_zero_r <= 1'b0;
      rd_vld_r   <= pop_s;
      if (rd_vld_r) begin
        mac_data_r <= data_sel_s;
        mac_wr_r   <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (req0_s && (!req1_s || last_grant_r)) begin
            ch_r       <= 1'b0;
            grant_r    <= 2'b01;
            rden_wcf_r <= 2'b01;
            state_r    <= CNT_RD;
          end else if (req1_s) begin
            ch_r       <= 1'b1;
            grant_r    <= 2'b10;
            rden_wcf_r <= 2'b10;
            state_r    <= CNT_RD;
          end else begin
            state_r <= IDLE;
          end
        end
        CNT_RD: begin
          state_r <= CNT_LAT;
        end
        CNT_LAT: begin
          cnt_word_r <= bcnt_sel_s;
          if (bcnt_sel_s[15:0] == 16'd0) begin
            err_zero_r  <= 1'b1;
            zero_drop_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            zero_drop_r <= 1'b0;
            qw_r        <= qw_sum_s[16:3];
            remaining_r <= qw_sum_s[16:3];
            state_r     <= WAIT_SPACE;
          end
        end
        WAIT_SPACE: begin
          if (free_s > qw_r) begin
            mac_data_r       <= DATA_WIDTH'(cnt_word_r);
            mac_wr_r         <= 1'b1;
            ipcs_data_r      <= DATA_WIDTH'(cnt_word_r) << (DATA_WIDTH - BCNT_WIDTH);
            ipcs_wr_r        <= 1'b1;
            rden_wf_r[ch_r]  <= ~empty_sel_s;
            state_r          <= DATA;
          end else begin
            state_r <= WAIT_SPACE;
          end
        end
        DATA: begin
          remaining_r     <= rem_next_s;
          rden_wf_r[ch_r] <= (rem_next_s != 14'd0) & ~empty_sel_s;
          // remaining_r==0 implies no read in flight beyond the write issued now
          if (remaining_r == 14'd0) begin
            state_r <= DONE;
          end else begin
            state_r <= DATA;
          end
        end
        DONE: begin
          pkt_done_r   <= ~zero_drop_r;
          last_grant_r <= ch_r;
          grant_r      <= 2'b00;
          rden_wf_r    <= 2'b00;
          state_r      <= IDLE;
        end
        default: begin
          grant_r   <= 2'b00;
          rden_wf_r <= 2'b00;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.rden_wf0          = rden_wf_r[0];
  assign bus.rden_wf1          = rden_wf_r[1];
  assign bus.rden_wcf0         = rden_wcf_r[0];
  assign bus.rden_wcf1         = rden_wcf_r[1];
  assign bus.fib_mac_data      = mac_data_r;
  assign bus.fib_mac_wr        = mac_wr_r;
  assign bus.fib_mac_ipcs_data = ipcs_data_r;
  assign bus.fib_mac_ipcs_wr   = ipcs_wr_r;
  assign bus.grant             = grant_r;
  assign bus.pkt_done          = pkt_done_r;
  assign bus.err_zero          = err_zero_r;

endmodule

// File: tb/tb_fib_tx_arb2.sv
// Directed bench for fib_tx_arb2: FIFO models on both channels, a negedge
// monitor logging FMAC writes, and a vector table plus corner-case sequences.
module tb_fib_tx_arb2;

  logic clk_fib = 1'b0;
  logic reset_;
  always #5 clk_fib = ~clk_fib;

  fib_tx_arb2_if #(.DATA_WIDTH(64), .BCNT_WIDTH(32)) bus ();
  fib_tx_arb2 #(.DATA_WIDTH(64), .BCNT_WIDTH(32)) dut (
    .clk_fib (clk_fib),
    .reset_  (reset_),
    .bus     (bus)
  );

  // ---------------- FIFO models (1-cycle read latency, guarded pop) -------
  logic [63:0] mem_d0 [0:255];
  logic [63:0] mem_d1 [0:255];
  logic [31:0] mem_c0 [0:63];
  logic [31:0] mem_c1 [0:63];
  int wp_d0 = 0, wp_d1 = 0, wp_c0 = 0, wp_c1 = 0;
  int rp_d0 = 0, rp_d1 = 0, rp_c0 = 0, rp_c1 = 0;
  logic [63:0] q_d0 = 64'd0, q_d1 = 64'd0;
  logic [31:0] q_c0 = 32'd0, q_c1 = 32'd0;
  logic force_e1 = 1'b0;
  logic flush = 1'b0;
  logic [12:0] usedw = 13'd0;

  assign bus.rdempty_wf0   = (rp_d0 == wp_d0);
  assign bus.rdempty_wf1   = (rp_d1 == wp_d1) || force_e1;
  assign bus.rdempty_wcf0  = (rp_c0 == wp_c0);
  assign bus.rdempty_wcf1  = (rp_c1 == wp_c1);
  assign bus.dataout_wf0   = q_d0;
  assign bus.dataout_wf1   = q_d1;
  assign bus.dataout_wcf0  = q_c0;
  assign bus.dataout_wcf1  = q_c1;
  assign bus.fib_mac_usedw = usedw;

  always @(posedge clk_fib) begin
    if (flush) begin
      rp_d0 <= wp_d0; rp_d1 <= wp_d1; rp_c0 <= wp_c0; rp_c1 <= wp_c1;
    end else begin
      if (bus.rden_wf0 && !bus.rdempty_wf0) begin q_d0 <= mem_d0[rp_d0]; rp_d0 <= rp_d0 + 1; end
      if (bus.rden_wf1 && !bus.rdempty_wf1) begin q_d1 <= mem_d1[rp_d1]; rp_d1 <= rp_d1 + 1; end
      if (bus.rden_wcf0 && !bus.rdempty_wcf0) begin q_c0 <= mem_c0[rp_c0]; rp_c0 <= rp_c0 + 1; end
      if (bus.rden_wcf1 && !bus.rdempty_wcf1) begin q_c1 <= mem_c1[rp_c1]; rp_c1 <= rp_c1 + 1; end
    end
  end

  // ---------------- Monitor ----------------
  logic [63:0] wlog [$];
  logic [63:0] ilog [$];
  int order [$];
  int n_done = 0, n_err = 0, n_wf_rd = 0, viol = 0;
  logic [1:0] prev_grant = 2'b00;

  always @(negedge clk_fib) begin
    if (bus.fib_mac_wr) wlog.push_back(bus.fib_mac_data);
    if (bus.fib_mac_ipcs_wr) ilog.push_back(bus.fib_mac_ipcs_data);
    if (bus.pkt_done) n_done <= n_done + 1;
    if (bus.err_zero) n_err <= n_err + 1;
    if (bus.rden_wcf0) order.push_back(0);
    if (bus.rden_wcf1) order.push_back(1);
    if (bus.rden_wf0 || bus.rden_wf1) n_wf_rd <= n_wf_rd + 1;
    if ((bus.rden_wf0 || bus.rden_wcf0) && bus.grant != 2'b01) viol <= viol + 1;
    else if ((bus.rden_wf1 || bus.rden_wcf1) && bus.grant != 2'b10) viol <= viol + 1;
    else if (prev_grant != 2'b00 && bus.grant != 2'b00 && bus.grant != prev_grant) viol <= viol + 1;
    prev_grant <= bus.grant;
  end

  // ---------------- Checking helpers ----------------
  int compared = 0;
  int mismatched = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_fib); #1; end
  endtask

  task automatic push_data(input int ch, input logic [63:0] w);
    if (ch == 0) begin mem_d0[wp_d0] = w; wp_d0 = wp_d0 + 1; end
    else begin mem_d1[wp_d1] = w; wp_d1 = wp_d1 + 1; end
  endtask

  task automatic push_cnt(input int ch, input logic [31:0] c);
    if (ch == 0) begin mem_c0[wp_c0] = c; wp_c0 = wp_c0 + 1; end
    else begin mem_c1[wp_c1] = c; wp_c1 = wp_c1 + 1; end
  endtask

  task automatic flush_fifos();
    flush = 1'b1; tick(1); flush = 1'b0;
  endtask

  task automatic wait_events(input int base, input int target, input int budget);
    int t;
    t = 0;
    while ((n_done + n_err - base) < target && t < budget) begin tick(1); t++; end
    check("event_wait", 64'((n_done + n_err - base) >= target), 64'd1);
  endtask

  logic [63:0] expq [$];

  task automatic compare_writes(input int bw, input string nm);
    check({nm, "_nwr"}, 64'(wlog.size() - bw), 64'(expq.size()));
    for (int k = 0; k < expq.size(); k++) begin
      if (bw + k < wlog.size()) check({nm, "_wdata"}, wlog[bw + k], expq[k]);
    end
  endtask

  // Queues one packet on a channel and appends its expected FMAC writes.
  task automatic add_pkt(input int ch, input logic [15:0] bcnt, input int qw, input int tag);
    logic [31:0] cw;
    logic [63:0] w;
    cw = {16'h5A00 + 16'(tag), bcnt};
    expq.push_back({32'd0, cw});
    for (int k = 0; k < qw; k++) begin
      w = {16'hDA7A, 8'(ch), 8'(tag), 32'(k)};
      push_data(ch, w);
      expq.push_back(w);
    end
    push_cnt(ch, cw);
  endtask

  typedef struct {
    int          ch;
    logic [15:0] bcnt;
    logic [12:0] usedw;
    int          qw;     // expected qword count, 0 = zero-length drop
  } vec_t;

  vec_t vecs [8];
  int bw, bi, bd, be, br, bo, bv;
  logic [31:0] cw;

  initial begin
    vecs[0] = '{0, 16'd20,  13'd0,     3};
    vecs[1] = '{1, 16'd8,   13'd0,     1};
    vecs[2] = '{0, 16'd1,   13'd100,   1};
    vecs[3] = '{1, 16'd9,   13'd0,     2};
    vecs[4] = '{0, 16'd0,   13'd0,     0};
    vecs[5] = '{1, 16'd64,  13'h1000,  8};
    vecs[6] = '{0, 16'd256, 13'd5,     32};
    vecs[7] = '{1, 16'd7,   13'd0,     1};

    // Reset state
    reset_ = 1'b0;
    tick(3);
    check("rst_grant", 64'(bus.grant), 64'd0);
    check("rst_wr", 64'({bus.fib_mac_wr, bus.fib_mac_ipcs_wr}), 64'd0);
    check("rst_pulses", 64'({bus.pkt_done, bus.err_zero}), 64'd0);
    check("rst_rden", 64'({bus.rden_wf0, bus.rden_wf1, bus.rden_wcf0, bus.rden_wcf1}), 64'd0);
    check("rst_data", bus.fib_mac_data, 64'd0);
    check("rst_ipcs", bus.fib_mac_ipcs_data, 64'd0);
    reset_ = 1'b1;
    tick(2);
    bv = viol;

    // Both channels requesting: ch0 wins first tie after reset, then alternate
    bw = wlog.size(); bo = order.size(); bd = n_done + n_err;
    expq.delete();
    add_pkt(0, 16'd8, 1, 8'h10);
    add_pkt(1, 16'd8, 1, 8'h11);
    add_pkt(0, 16'd8, 1, 8'h12);
    add_pkt(1, 16'd8, 1, 8'h13);
    wait_events(bd, 4, 400);
    tick(3);
    for (int k = 0; k < 4; k++) begin
      if (bo + k < order.size()) check("rr_order", 64'(order[bo + k]), 64'(k % 2));
      else check("rr_order_len", 64'(order.size() - bo), 64'd4);
    end
    compare_writes(bw, "rr");
    flush_fifos();

    // Table-driven single packets
    for (int i = 0; i < 8; i++) begin
      bw = wlog.size(); bi = ilog.size(); bd = n_done; be = n_err; br = n_wf_rd;
      usedw = vecs[i].usedw;
      expq.delete();
      cw = {16'h5A00 + 16'(i), vecs[i].bcnt};
      if (vecs[i].qw == 0) begin
        push_data(vecs[i].ch, 64'hDEAD_0000_0000_0000);
        push_cnt(vecs[i].ch, cw);
      end else begin
        add_pkt(vecs[i].ch, vecs[i].bcnt, vecs[i].qw, i);
      end
      wait_events(bd + be, 1, 2000);
      tick(4);
      compare_writes(bw, "vec");
      check("vec_ipcs_n", 64'(ilog.size() - bi), 64'(vecs[i].qw > 0));
      if (vecs[i].qw > 0 && ilog.size() > bi) check("vec_ipcs_data", ilog[bi], {cw, 32'd0});
      if (vecs[i].qw > 0) check("vec_hold", bus.fib_mac_data, expq[expq.size() - 1]);
      check("vec_pkt_done", 64'(n_done - bd), 64'(vecs[i].qw > 0));
      check("vec_err_zero", 64'(n_err - be), 64'(vecs[i].qw == 0));
      check("vec_rden_cycles", 64'(n_wf_rd - br), 64'(vecs[i].qw));
      flush_fifos();
    end

    // FMAC space: hold while free <= qw (free 7, then 8 == qw), go at free 9
    bw = wlog.size(); bd = n_done + n_err;
    usedw = 13'h1FF8;
    expq.delete();
    add_pkt(0, 16'd64, 8, 8'h30);
    tick(30);
    check("space_hold_wr", 64'(wlog.size() - bw), 64'd0);
    check("space_hold_grant", 64'(bus.grant), 64'h1);
    usedw = 13'h1FF7;
    tick(20);
    check("space_edge_wr", 64'(wlog.size() - bw), 64'd0);
    usedw = 13'h1FF6;
    wait_events(bd, 1, 200);
    tick(3);
    compare_writes(bw, "space");
    usedw = 13'd0;
    flush_fifos();

    // Ch1 data FIFO runs dry for 5 cycles right after the first read
    bw = wlog.size(); bd = n_done + n_err; br = 0;
    expq.delete();
    add_pkt(1, 16'd24, 3, 8'h31);
    while (!bus.rden_wf1 && br < 100) begin tick(1); br++; end
    check("stall_saw_rden", 64'(bus.rden_wf1), 64'd1);
    tick(1);
    force_e1 = 1'b1;
    tick(5);
    force_e1 = 1'b0;
    wait_events(bd, 1, 200);
    tick(3);
    compare_writes(bw, "stall");
    flush_fifos();

    // bcnt=FFFF needs 8192 qwords, more than an empty FMAC FIFO offers
    bw = wlog.size(); bd = n_done + n_err; br = n_wf_rd;
    push_data(0, 64'h0BAD_0000_0000_0001);
    push_cnt(0, 32'h0000_FFFF);
    tick(200);
    check("ffff_no_wr", 64'(wlog.size() - bw), 64'd0);
    check("ffff_no_rden", 64'(n_wf_rd - br), 64'd0);
    check("ffff_grant", 64'(bus.grant), 64'h1);
    check("ffff_no_event", 64'(n_done + n_err - bd), 64'd0);
    reset_ = 1'b0;
    flush_fifos();
    tick(1);
    reset_ = 1'b1;
    tick(2);

    // Reset in the middle of a long packet
    bw = wlog.size(); bd = n_done;
    expq.delete();
    add_pkt(1, 16'd256, 32, 8'h40);
    br = 0;
    while ((wlog.size() - bw) < 5 && br < 200) begin tick(1); br++; end
    check("abort_started", 64'((wlog.size() - bw) >= 5), 64'd1);
    reset_ = 1'b0;
    tick(1);
    check("abort_wr", 64'({bus.fib_mac_wr, bus.fib_mac_ipcs_wr}), 64'd0);
    check("abort_rden", 64'({bus.rden_wf1, bus.rden_wcf1}), 64'd0);
    check("abort_grant", 64'(bus.grant), 64'd0);
    bw = wlog.size(); br = n_wf_rd;
    flush_fifos();
    tick(1);
    reset_ = 1'b1;
    tick(10);
    check("abort_no_wr", 64'(wlog.size() - bw), 64'd0);
    check("abort_no_rden", 64'(n_wf_rd - br), 64'd0);
    check("abort_no_done", 64'(n_done - bd), 64'd0);
    check("abort_idle_grant", 64'(bus.grant), 64'd0);

    // After reset the tie again goes to ch0
    bw = wlog.size(); bo = order.size(); bd = n_done + n_err;
    expq.delete();
    add_pkt(0, 16'd8, 1, 8'h50);
    add_pkt(1, 16'd8, 1, 8'h51);
    wait_events(bd, 2, 200);
    tick(3);
    if (order.size() - bo >= 2) begin
      check("post_rst_first", 64'(order[bo]), 64'd0);
      check("post_rst_second", 64'(order[bo + 1]), 64'd1);
    end else begin
      check("post_rst_order_len", 64'(order.size() - bo), 64'd2);
    end
    compare_writes(bw, "post_rst");

    check("grant_rules", 64'(viol - bv), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
